// File: rtl/shift_unit.sv
// shift_unit: two-stage pipelined 2x-width shifter/rotator with valid/ready handshake.
//   Stage 1 extends the operand and applies the coarse shift (multiples of 8).
//   Stage 2 applies the fine shift (0..7) and holds the result.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      request handshake
//   in_data [DATA_W]       operand
//   in_amount [AMT_W]      unsigned shift amount
//   in_mode [2]            00 expand-left, 01 logical-right, 10 arith-right, 11 rotate-left
//   out_valid/out_ready    result handshake
//   out_data [OUT_W]       result
//   out_sticky             OR of 1-bits lost off the window (only with SHIFT_UNIT_STICKY_EN)
// Build option: define SHIFT_UNIT_STICKY_EN to add the out_sticky port and its logic.
module shift_unit #(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned OUT_W  = 2 * DATA_W,
  localparam int unsigned AMT_W  = $clog2(OUT_W) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [AMT_W-1:0]   in_amount,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef SHIFT_UNIT_STICKY_EN
  output logic               out_sticky,
`endif
  output logic [OUT_W-1:0]   out_data
);

  localparam logic [1:0] MODE_SHL = 2'b00;
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_SAR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;
  localparam logic [OUT_W-1:0] ONES = '1;

  logic             s1_valid;
  logic [OUT_W-1:0] s1_data;
  logic [1:0]       s1_mode;
  logic [2:0]       s1_fine;

  logic             s2_load;
  logic [OUT_W-1:0] ext_c;
  logic [AMT_W-1:0] coarse_amt_c;
  logic [AMT_W-1:0] rot_amt_c;
  logic [OUT_W-1:0] coarse_c;
  logic [AMT_W-1:0] fine_back_c;
  logic [OUT_W-1:0] fine_c;

  // Stage 2 may load when empty or when its result leaves this cycle.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Stage 1: extend and coarse shift; rotate uses the amount modulo OUT_W.
  always_comb begin
    ext_c        = {{DATA_W{in_data[DATA_W-1] & (in_mode == MODE_SAR)}}, in_data};
    coarse_amt_c = {in_amount[AMT_W-1:3], 3'b000};
    rot_amt_c    = {1'b0, in_amount[AMT_W-2:3], 3'b000};
    coarse_c     = '0;
    case (in_mode)
      MODE_SHL: coarse_c = ext_c << coarse_amt_c;
      MODE_SHR: coarse_c = ext_c >> coarse_amt_c;
      MODE_SAR: coarse_c = OUT_W'($signed(ext_c) >>> coarse_amt_c);
      MODE_ROL: coarse_c = (ext_c << rot_amt_c) | (ext_c >> (AMT_W'(OUT_W) - rot_amt_c));
      default:  coarse_c = '0;
    endcase
  end

  // Stage 2: fine shift of 0..7 bits on the stage-1 contents.
  always_comb begin
    fine_back_c = AMT_W'(OUT_W) - AMT_W'(s1_fine);
    fine_c      = '0;
    case (s1_mode)
      MODE_SHL: fine_c = s1_data << s1_fine;
      MODE_SHR: fine_c = s1_data >> s1_fine;
      MODE_SAR: fine_c = OUT_W'($signed(s1_data) >>> s1_fine);
      MODE_ROL: fine_c = (s1_data << s1_fine) | (s1_data >> fine_back_c);
      default:  fine_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
      s1_fine  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= coarse_c;
        s1_mode <= in_mode;
        s1_fine <= in_amount[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= fine_c;
      end
    end
  end

`ifdef SHIFT_UNIT_STICKY_EN
  logic s1_sticky;
  logic coarse_lost_c;
  logic fine_lost_c;

  // Lost bits: top bits for left shifts, bottom bits for right shifts, none for rotate.
  always_comb begin
    coarse_lost_c = 1'b0;
    case (in_mode)
      MODE_SHL: coarse_lost_c = |(ext_c & ~(ONES >> coarse_amt_c));
      MODE_SHR,
      MODE_SAR: coarse_lost_c = |(ext_c & ~(ONES << coarse_amt_c));
      default:  coarse_lost_c = 1'b0;
    endcase
  end

  always_comb begin
    fine_lost_c = 1'b0;
    case (s1_mode)
      MODE_SHL: fine_lost_c = |(s1_data & ~(ONES >> s1_fine));
      MODE_SHR,
      MODE_SAR: fine_lost_c = |(s1_data & ~(ONES << s1_fine));
      default:  fine_lost_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sticky <= 1'b0;
    end else if (in_ready && in_valid) begin
      s1_sticky <= coarse_lost_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sticky <= 1'b0;
    end else if (s2_load && s1_valid) begin
      out_sticky <= s1_sticky | fine_lost_c;
    end
  end
`endif

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: table-driven vectors plus hand-written pipeline sequences for shift_unit,
// results checked in order through an expected-value queue.
module tb_shift_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OUT_W  = 64;
  localparam int unsigned AMT_W  = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amount;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
`ifdef SHIFT_UNIT_STICKY_EN
  logic              out_sticky;
`endif

  shift_unit #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SHIFT_UNIT_STICKY_EN
    .out_sticky(out_sticky),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        mode;
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic [OUT_W-1:0]  exp_data;
    logic              exp_sticky;
  } vec_t;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             sticky;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t cur_exp;
  logic stall_prev = 1'b0;
  logic [OUT_W-1:0] held;
  logic rand_rdy = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Bit-level reference: each source bit either lands in the window or is lost.
  function automatic exp_t model(input logic [1:0] mode, input logic [DATA_W-1:0] d,
                                 input logic [AMT_W-1:0] amt);
    exp_t r;
    logic [OUT_W-1:0] ext;
    int a;
    a = int'(amt);
    ext = (mode == 2'b10) ? {{DATA_W{d[DATA_W-1]}}, d} : {{DATA_W{1'b0}}, d};
    r.data = '0;
    r.sticky = 1'b0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      case (mode)
        2'b00: if (i + a < int'(OUT_W)) r.data[i + a] = ext[i]; else r.sticky |= ext[i];
        2'b11: r.data[(i + a) % int'(OUT_W)] = ext[i];
        default: if (i >= a) r.data[i - a] = ext[i]; else r.sticky |= ext[i];
      endcase
    end
    if (mode == 2'b10)
      for (int j = 0; j < int'(OUT_W); j++)
        if (j + a >= int'(OUT_W)) r.data[j] = ext[OUT_W-1];
    return r;
  endfunction

  // Output side: stability while stalled, in-order scoreboard on handshake, push on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && out_valid) check("hold_stable", 128'(out_data), 128'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 128'(out_data), 128'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", 128'(out_data), 128'(e.data));
`ifdef SHIFT_UNIT_STICKY_EN
          check("out_sticky", 128'(out_sticky), 128'(e.sticky));
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
      stall_prev <= out_valid && !out_ready;
      held <= out_data;
    end
  end

  // Present a request and wait until it is accepted; returns at posedge+1 after acceptance.
  task automatic send(input logic [1:0] mode, input logic [DATA_W-1:0] d,
                      input logic [AMT_W-1:0] amt, input exp_t e);
    logic acc;
    int   n;
    in_valid  = 1'b1;
    in_mode   = mode;
    in_data   = d;
    in_amount = amt;
    cur_exp   = e;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      n++;
    end while (!acc && n < 60);
    if (!acc) check("accept_timeout", 128'(n), 128'(0));
    in_valid = 1'b0;
    in_data  = $urandom();
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", 128'(sb.size()), 128'(0));
  endtask

  vec_t vecs[12];
  exp_t e;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 32'h3AE51959, 7'd4,   64'h00000003AE519590, 1'b0};
    vecs[1]  = '{2'b10, 32'h80000000, 7'd4,   64'hFFFFFFFFF8000000, 1'b0};
    vecs[2]  = '{2'b01, 32'h80000000, 7'd4,   64'h0000000008000000, 1'b0};
    vecs[3]  = '{2'b11, 32'h3AE51959, 7'd48,  64'h1959000000003AE5, 1'b0};
    vecs[4]  = '{2'b11, 32'h3AE51959, 7'd112, 64'h1959000000003AE5, 1'b0};
    vecs[5]  = '{2'b00, 32'h00000001, 7'd64,  64'h0,                1'b1};
    vecs[6]  = '{2'b00, 32'h00000001, 7'd127, 64'h0,                1'b1};
    vecs[7]  = '{2'b10, 32'hFFFFFFFF, 7'd100, 64'hFFFFFFFFFFFFFFFF, 1'b1};
    vecs[8]  = '{2'b01, 32'hFFFFFFFF, 7'd3,   64'h000000001FFFFFFF, 1'b1};
    vecs[9]  = '{2'b00, 32'hDEADBEEF, 7'd0,   64'h00000000DEADBEEF, 1'b0};
    vecs[10] = '{2'b11, 32'h80000000, 7'd33,  64'h0000000000000001, 1'b0};
    vecs[11] = '{2'b00, 32'h80000000, 7'd32,  64'h8000000000000000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amount = '0; in_mode = '0;
    out_ready = 1'b1; cur_exp = '{64'h0, 1'b0};
    #2;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Two-cycle latency on an empty pipe.
    in_valid = 1'b1; in_mode = 2'b00; in_data = 32'h3AE51959; in_amount = 7'd4;
    cur_exp = '{64'h00000003AE519590, 1'b0};
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_edge1_valid", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    check("lat_edge2_valid", 128'(out_valid), 128'(1));
    check("lat_edge2_data", 128'(out_data), 128'(64'h00000003AE519590));
    drain();

    // Table vectors back-to-back with out_ready high.
    for (int i = 0; i < 12; i++) begin
      e = '{vecs[i].exp_data, vecs[i].exp_sticky};
      send(vecs[i].mode, vecs[i].data, vecs[i].amt, e);
    end
    drain();

    // Backpressure: 4 requests, 3 stalled cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [DATA_W-1:0] d;
      d = $urandom();
      send(2'(i), d, 7'(i * 9 + 5), model(2'(i), d, 7'(i * 9 + 5)));
    end
    check("full_in_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("stall_in_ready", 128'(in_ready), 128'(0));
      check("stall_out_valid", 128'(out_valid), 128'(1));
    end
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      logic [DATA_W-1:0] d;
      d = $urandom();
      send(2'(i), d, 7'(i * 13 + 3), model(2'(i), d, 7'(i * 13 + 3)));
    end
    drain();

    // Reset with two requests in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [DATA_W-1:0] d;
      d = $urandom();
      send(2'b01, d, 7'd7, model(2'b01, d, 7'd7));
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("release_in_ready", 128'(in_ready), 128'(1));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("no_stale_valid", 128'(out_valid), 128'(0));
    end
    e = model(2'b10, 32'h80000000, 7'd4);
    send(2'b10, 32'h80000000, 7'd4, e);
    drain();

    // Random traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [1:0]        m;
      logic [DATA_W-1:0] d;
      logic [AMT_W-1:0]  a;
      m = 2'($urandom_range(0, 3));
      d = $urandom();
      a = 7'($urandom_range(0, 127));
      send(m, d, a, model(m, d, a));
    end
    rand_rdy = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning input operand width; power of two, legal range 8..64.
REQ-002 SHALL derive localparam OUT_W = 2*DATA_W (result width) and AMT_W = $clog2(OUT_W)+1 (shift-amount width; 7 at default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit accepts a request this cycle.
REQ-007 in_data  input  DATA_W  operand.
REQ-008 in_amount  input  AMT_W  shift amount, unsigned.
REQ-009 in_mode  input  2  00 expand-left, 01 logical-right, 10 arithmetic-right, 11 rotate-left.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  OUT_W  result.
REQ-013 out_sticky  output  1  OR of all 1-bits shifted out of the OUT_W window (present only with the macro in REQ-030).

Function
REQ-014 SHALL extend in_data to OUT_W before shifting: sign-extension for mode 10, zero-extension for all other modes.
REQ-015 Mode 00 SHALL produce ext << in_amount; mode 01 SHALL produce ext >> in_amount with zero fill; mode 10 SHALL produce ext >>> in_amount with sign fill; mode 11 SHALL rotate ext left by in_amount mod OUT_W.
REQ-016 For in_amount >= OUT_W: modes 00/01 SHALL output 0; mode 10 SHALL output all copies of the sign bit; mode 11 SHALL use amount mod OUT_W.
REQ-017 SHALL be a two-stage pipeline: stage 1 registers the extended operand after the coarse shift (amount bits AMT_W-1..3); stage 2 registers the fine shift (bits 2..0) and the result.
REQ-018 Latency SHALL be exactly 2 cycles from the accepting edge (in_valid && in_ready) to out_valid high when out_ready stays high.
REQ-019 Throughput SHALL be one result per cycle with no bubbles while out_ready stays high.
REQ-020 Each stage SHALL load when it is empty or its contents advance in the same cycle; in_ready = !s1_valid || stage-1 advancing.
REQ-021 While out_valid && !out_ready, out_data and out_sticky SHALL hold stable and stage 2 SHALL NOT change.
REQ-022 With both stages full and out_ready low, in_ready SHALL be 0; no request SHALL be lost or duplicated, and results SHALL leave in acceptance order.
REQ-023 Simultaneous output handshake and input acceptance in a full pipe SHALL shift both stages forward in the same cycle.
REQ-024 in_data/in_amount/in_mode SHALL be sampled only on an accepting edge; changes at other times SHALL have no effect.

Reset
REQ-025 Asserting rst_n low SHALL asynchronously clear both stage valid flags, out_valid=0, out_data=0, out_sticky=0.
REQ-026 in_ready SHALL be 1 during reset and on the first cycle after deassertion.
REQ-027 Reset mid-operation SHALL discard all in-flight requests; no stale result SHALL appear after release.
REQ-028 Deassertion SHALL take effect on the next rising edge of clk; the first request may be accepted on that edge.

Configuration
REQ-029 Exactly one compile-time option SHALL exist: macro SHIFT_UNIT_STICKY_EN.
REQ-030 With SHIFT_UNIT_STICKY_EN defined: port out_sticky SHALL exist, computed per stage and carried down the pipe. Modes 00/01/10 SHALL report any lost 1-bit (mode 10 tests bits shifted below bit 0), and mode 11 SHALL report 0.
REQ-031 Without the macro: out_sticky port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Mode 00, in_data=32'h3AE51959, amount=4, out_ready=1 -> out_data=64'h00000003AE519590 exactly 2 cycles later, sticky=0.
REQ-033 Mode 10, in_data=32'h80000000, amount=4 -> out_data=64'hFFFFFFFFF8000000; mode 01 with the same inputs -> 64'h0000000008000000.
REQ-034 Mode 11, in_data=32'h3AE51959, amount=48 -> 64'h19590000_00003AE5. Amount=112 (mod 64 = 48) -> same result, sticky=0.
REQ-035 Mode 00, in_data=32'h00000001, amount=64 -> out_data=0, sticky=1. Amount=127 -> 0. Mode 10 with in_data=32'hFFFFFFFF, amount=100 -> all ones.
REQ-036 Issue 4 back-to-back requests, hold out_ready=0 for 3 cycles -> in_ready drops after 2 acceptances, out_data stable, then 4 results in order with no loss.
REQ-037 Assert rst_n low with 2 requests in flight -> out_valid=0 immediately; after release, no result until a new request is accepted.
